// File: rtl/cc_mux21_arbiter.sv
// Round-robin arbiter that shares one 2:1 mux datapath between two
// valid/ready requesters, feeding a one-entry registered output stage.
// The current owner may hold the grant for up to BURST_MAX back-to-back
// words while the other side is requesting; a lone requester is never
// throttled. Sustains one transfer per cycle (drain and load overlap).
module cc_mux21_arbiter #(
    parameter int NUMBER_DATAWIDTH = 8,
    parameter int BURST_MAX        = 4
) (
    input  logic                        CC_MUXARB_CLOCK_50,
    input  logic                        CC_MUXARB_RESET_InLow,
    input  logic                        CC_MUXARB_valid1_In,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_MUXARB_data1_InBUS,
    output logic                        CC_MUXARB_ready1_Out,
    input  logic                        CC_MUXARB_valid2_In,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_MUXARB_data2_InBUS,
    output logic                        CC_MUXARB_ready2_Out,
    output logic [NUMBER_DATAWIDTH-1:0] CC_MUXARB_z_OutBUS,
    output logic                        CC_MUXARB_valid_Out,
    input  logic                        CC_MUXARB_ready_In,
    output logic                        CC_MUXARB_select_OutBUS
);

    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN1 = 2'd1,
        OWN2 = 2'd2
    } state_t;

    state_t                      state_q;
    logic [CW-1:0]               cnt_q;
    logic [CW-1:0]               cnt_d;
    logic                        last2_q;   // 1: most recent winner was requester 2
    logic [NUMBER_DATAWIDTH-1:0] z_q;
    logic                        valid_q;
    logic                        select_q;

    logic                        can_load;
    logic                        cnt_at_max;
    logic                        win1;
    logic                        win2;
    logic                        take1;
    logic                        take2;
    logic                        same_owner;
    logic [NUMBER_DATAWIDTH-1:0] mux_data;

    assign can_load   = !valid_q || CC_MUXARB_ready_In;
    assign cnt_at_max = (cnt_q >= CNT_MAX);

    // Winner selection: tie-break on last winner when idle, burst limit while owned
    always_comb begin
        win1 = 1'b0;
        win2 = 1'b0;
        if (can_load) begin
            case (state_q)
                IDLE: begin
                    if (CC_MUXARB_valid1_In && CC_MUXARB_valid2_In) begin
                        win1 = last2_q;
                        win2 = !last2_q;
                    end else begin
                        win1 = CC_MUXARB_valid1_In;
                        win2 = CC_MUXARB_valid2_In;
                    end
                end
                OWN1: begin
                    if (CC_MUXARB_valid1_In && (!cnt_at_max || !CC_MUXARB_valid2_In))
                        win1 = 1'b1;
                    else if (CC_MUXARB_valid2_In)
                        win2 = 1'b1;
                end
                OWN2: begin
                    if (CC_MUXARB_valid2_In && (!cnt_at_max || !CC_MUXARB_valid1_In))
                        win2 = 1'b1;
                    else if (CC_MUXARB_valid1_In)
                        win1 = 1'b1;
                end
                default: begin
                    win1 = 1'b0;
                    win2 = 1'b0;
                end
            endcase
        end
    end

    // Readies are gated by reset so nothing is accepted while it is asserted
    assign CC_MUXARB_ready1_Out = CC_MUXARB_RESET_InLow && win1;
    assign CC_MUXARB_ready2_Out = CC_MUXARB_RESET_InLow && win2;

    assign take1 = CC_MUXARB_valid1_In && CC_MUXARB_ready1_Out;
    assign take2 = CC_MUXARB_valid2_In && CC_MUXARB_ready2_Out;

    // Shared 2:1 datapath steered by the grant
    assign mux_data = take2 ? CC_MUXARB_data2_InBUS : CC_MUXARB_data1_InBUS;

    // Burst counter: extend the run for the same owner, restart at 1 on a handover
    always_comb begin
        same_owner = (state_q == OWN1 && take1) || (state_q == OWN2 && take2);
        cnt_d      = CW'(1);
        if (same_owner)
            cnt_d = cnt_at_max ? cnt_q : cnt_q + 1'b1;
    end

    // Ownership FSM and registered output stage
    always_ff @(posedge CC_MUXARB_CLOCK_50 or negedge CC_MUXARB_RESET_InLow) begin
        if (!CC_MUXARB_RESET_InLow) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last2_q  <= 1'b1;
            z_q      <= '0;
            valid_q  <= 1'b0;
            select_q <= 1'b0;
        end else if (take1 || take2) begin
            z_q      <= mux_data;
            valid_q  <= 1'b1;
            select_q <= take2;
            last2_q  <= take2;
            state_q  <= take2 ? OWN2 : OWN1;
            cnt_q    <= cnt_d;
        end else begin
            if (valid_q && CC_MUXARB_ready_In)
                valid_q <= 1'b0;
            if (can_load && !CC_MUXARB_valid1_In && !CC_MUXARB_valid2_In) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end
        end
    end

    assign CC_MUXARB_z_OutBUS      = z_q;
    assign CC_MUXARB_valid_Out     = valid_q;
    assign CC_MUXARB_select_OutBUS = select_q;

endmodule

// File: tb/tb_cc_mux21_arbiter.sv
// Bench for cc_mux21_arbiter: directed vector tables for the documented
// scenarios, then randomized traffic against a grant/queue-level model.
module tb_cc_mux21_arbiter;

    localparam int NDW = 8;
    localparam int BM  = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           v1, v2, rdy;
    logic [NDW-1:0] d1, d2;
    logic           r1, r2, vo, sel;
    logic [NDW-1:0] z;

    always #5 clk = ~clk;

    cc_mux21_arbiter #(.NUMBER_DATAWIDTH(NDW), .BURST_MAX(BM)) dut (
        .CC_MUXARB_CLOCK_50     (clk),
        .CC_MUXARB_RESET_InLow  (rst_n),
        .CC_MUXARB_valid1_In    (v1),
        .CC_MUXARB_data1_InBUS  (d1),
        .CC_MUXARB_ready1_Out   (r1),
        .CC_MUXARB_valid2_In    (v2),
        .CC_MUXARB_data2_InBUS  (d2),
        .CC_MUXARB_ready2_Out   (r2),
        .CC_MUXARB_z_OutBUS     (z),
        .CC_MUXARB_valid_Out    (vo),
        .CC_MUXARB_ready_In     (rdy),
        .CC_MUXARB_select_OutBUS(sel)
    );

    typedef struct {
        logic           v1;
        logic [NDW-1:0] d1;
        logic           v2;
        logic [NDW-1:0] d2;
        logic           rdy;
        logic           er1;
        logic           er2;
        logic           evo;
        logic [NDW-1:0] ez;
        logic           esel;
    } vec_t;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic a1, input logic [7:0] a1d, input logic a2,
                                input logic [7:0] a2d, input logic ry, input logic e1,
                                input logic e2, input logic ev, input logic [7:0] ezz,
                                input logic es);
        vec_t t;
        t.v1 = a1; t.d1 = a1d; t.v2 = a2; t.d2 = a2d; t.rdy = ry;
        t.er1 = e1; t.er2 = e2; t.evo = ev; t.ez = ezz; t.esel = es;
        return t;
    endfunction

    // Called just after a falling edge: drive, check readies, clock, check outputs.
    task automatic run_vec(input vec_t t, input string tag);
        v1 = t.v1; d1 = t.d1; v2 = t.v2; d2 = t.d2; rdy = t.rdy;
        #1;
        chk({tag, ".ready1"}, r1, t.er1);
        chk({tag, ".ready2"}, r2, t.er2);
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, vo, t.evo);
        chk({tag, ".z"}, z, t.ez);
        chk({tag, ".select"}, sel, t.esel);
        $display("vec %s v=%b%b rdy=%b -> ready=%b%b z=%h valid=%b sel=%b",
                 tag, t.v1, t.v2, t.rdy, r1, r2, z, vo, sel);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: owner/run-length/last-winner bookkeeping plus an output register
    int             m_owner;   // 0 none, 1 or 2
    int             m_run;
    int             m_last;
    logic [NDW-1:0] m_z;
    logic           m_vo;
    logic           m_sel;

    task automatic model_reset();
        m_owner = 0; m_run = 0; m_last = 2; m_z = '0; m_vo = 1'b0; m_sel = 1'b0;
    endtask

    function automatic int model_grant();
        bit want[3];
        int other;
        want[0] = 1'b0; want[1] = v1; want[2] = v2;
        if (m_vo && !rdy) return 0;
        if (m_owner != 0) begin
            other = 3 - m_owner;
            if (want[m_owner] && (m_run < BM || !want[other])) return m_owner;
            if (want[other]) return other;
            return 0;
        end
        if (want[1] && want[2]) return 3 - m_last;
        if (want[1]) return 1;
        if (want[2]) return 2;
        return 0;
    endfunction

    task automatic model_clock(input int g);
        if (g != 0) begin
            m_z   = (g == 1) ? d1 : d2;
            m_vo  = 1'b1;
            m_sel = (g == 2);
            m_run = (g == m_owner) ? ((m_run < BM) ? m_run + 1 : BM) : 1;
            m_owner = g;
            m_last  = g;
        end else begin
            if (!v1 && !v2 && (!m_vo || rdy)) begin
                m_owner = 0;
                m_run   = 0;
            end
            if (m_vo && rdy) m_vo = 1'b0;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    vec_t tab3[9];
    vec_t seq[$];

    initial begin : main
        int g;
        int grants[9];
        grants = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
        for (int i = 0; i < 9; i++) begin
            logic [7:0] a, b;
            a = 8'h30 + 8'(i);
            b = 8'h60 + 8'(i);
            tab3[i] = mk(1, a, 1, b, 1, grants[i] == 1, grants[i] == 2, 1,
                         (grants[i] == 1) ? a : b, grants[i] == 2);
        end

        // Reset held with both requesters valid
        rst_n = 1'b0; v1 = 1'b1; v2 = 1'b1; rdy = 1'b1; d1 = 8'h30; d2 = 8'h60;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst.ready1", r1, 0);
        chk("rst.ready2", r2, 0);
        chk("rst.valid", vo, 0);
        chk("rst.z", z, 0);
        chk("rst.select", sel, 0);
        rst_n = 1'b1;
        #1;
        chk("rel.first_is_req1", r1, 1);
        chk("rel.req2_low", r2, 0);

        // Continuous contention: 4-word bursts alternate
        for (int i = 0; i < 9; i++) run_vec(tab3[i], $sformatf("burst%0d", i));

        // Single requester is never throttled
        do_reset();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a;
            a = 8'h11 + 8'(i);
            run_vec(mk(1, a, 0, 8'h00, 1, 1, 0, 1, a, 0), $sformatf("solo%0d", i));
        end

        // Owner req2 drops valid after 2 words, then stall and drain
        do_reset();
        seq.push_back(mk(0, 8'h40, 1, 8'h21, 1, 0, 1, 1, 8'h21, 1));
        seq.push_back(mk(1, 8'h41, 1, 8'h22, 1, 0, 1, 1, 8'h22, 1));
        seq.push_back(mk(1, 8'h42, 0, 8'h00, 1, 1, 0, 1, 8'h42, 0));
        seq.push_back(mk(1, 8'h43, 1, 8'h23, 1, 1, 0, 1, 8'h43, 0));
        seq.push_back(mk(1, 8'h44, 1, 8'h23, 1, 1, 0, 1, 8'h44, 0));
        seq.push_back(mk(1, 8'h45, 1, 8'h23, 1, 1, 0, 1, 8'h45, 0));
        seq.push_back(mk(1, 8'h46, 1, 8'h24, 1, 0, 1, 1, 8'h24, 1));
        seq.push_back(mk(1, 8'hA5, 0, 8'h00, 1, 1, 0, 1, 8'hA5, 0));
        seq.push_back(mk(1, 8'h77, 1, 8'h88, 0, 0, 0, 1, 8'hA5, 0));
        seq.push_back(mk(1, 8'h77, 1, 8'h88, 0, 0, 0, 1, 8'hA5, 0));
        seq.push_back(mk(1, 8'h77, 1, 8'h88, 0, 0, 0, 1, 8'hA5, 0));
        seq.push_back(mk(1, 8'h5A, 1, 8'h88, 1, 1, 0, 1, 8'h5A, 0));
        seq.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h5A, 0));
        foreach (seq[i]) run_vec(seq[i], $sformatf("seq%0d", i));

        // Reset asserted mid-burst
        do_reset();
        for (int i = 0; i < 3; i++) begin
            logic [7:0] a;
            a = 8'h51 + 8'(i);
            run_vec(mk(1, a, 1, 8'h91, 1, 1, 0, 1, a, 0), $sformatf("mid%0d", i));
        end
        rst_n = 1'b0;
        #1;
        chk("midrst.valid", vo, 0);
        chk("midrst.z", z, 0);
        chk("midrst.ready1", r1, 0);
        chk("midrst.ready2", r2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk(1, 8'h61, 1, 8'h92, 1, 1, 0, 1, 8'h61, 0), "midrst.tie");

        // Randomized traffic against the model
        do_reset();
        model_reset();
        for (int i = 0; i < 600; i++) begin
            v1  = ($urandom_range(0, 3) != 0);
            v2  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            d1  = 8'($urandom);
            d2  = 8'($urandom);
            #1;
            g = model_grant();
            chk($sformatf("rnd%0d.ready1", i), r1, g == 1);
            chk($sformatf("rnd%0d.ready2", i), r2, g == 2);
            @(posedge clk);
            model_clock(g);
            #1;
            chk($sformatf("rnd%0d.valid", i), vo, m_vo);
            chk($sformatf("rnd%0d.z", i), z, m_z);
            chk($sformatf("rnd%0d.select", i), sel, m_sel);
            $display("rnd %0d v=%b%b rdy=%b grant=%0d z=%h valid=%b sel=%b",
                     i, v1, v2, rdy, g, z, vo, sel);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
